dac_sample_sched: RTL
=====================

DAC_SAMPLE_SCHED -- requirements
Module: dac_sample_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 10: DAC code width, matching avsddac.
REQ-002 SHALL have parameter DEPTH, default 8: sample FIFO depth, power of two.
REQ-003 SHALL have parameter DIV_W, default 16: rate divider width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  producer (RVMyth store path) offers a sample.
REQ-007 SHALL have port in_data  input  DATA_W  sample code.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept; push = in_valid & in_ready.
REQ-009 SHALL have port enable  input  1  playback enable.
REQ-010 SHALL have port rate_div  input  DIV_W  sample period = rate_div+1 clk cycles.
REQ-011 SHALL have port clr_underflow  input  1  clears sticky underflow flag.
REQ-012 SHALL have port dac_code  output  DATA_W  registered code driving the DAC D input.
REQ-013 SHALL have port dac_strobe  output  1  one-cycle pulse, high in the first cycle a new dac_code is presented.
REQ-014 SHALL have port underflow  output  1  sticky: sample tick occurred with FIFO empty.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 in_ready SHALL equal (level != DEPTH), derived from registered count; a push to a full FIFO SHALL NOT be accepted, even when a pop occurs in the same cycle.
REQ-017 A push and pop in the same cycle on a non-empty, non-full FIFO SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 FSM states SHALL be IDLE, PRIME, RUN.
REQ-019 IDLE: enable=1 -> PRIME; otherwise stay; no pops; dac_code holds.
REQ-020 PRIME: enable=0 -> IDLE; level>=1 -> RUN with divider counter loaded to 0.
REQ-021 RUN: a tick SHALL occur when the counter is 0; the counter then reloads rate_div, sampled at reload; otherwise it decrements.
REQ-022 On tick with level>=1: pop the head; dac_code SHALL take the popped value next cycle, with dac_strobe high that cycle.
REQ-023 On tick with level==0: dac_code SHALL hold, underflow SHALL set, FSM SHALL go to PRIME.
REQ-024 enable=0 in RUN SHALL go to IDLE next cycle without popping; FIFO contents are retained.
REQ-025 The first sample after entering RUN SHALL pop in the first RUN cycle; subsequent pops SHALL be exactly rate_div+1 cycles apart; rate_div=0 gives one pop per cycle.
REQ-026 underflow SHALL clear on clr_underflow; if a set and a clear occur in the same cycle, set SHALL win.
REQ-027 dac_strobe SHALL never be high for two consecutive cycles unless rate_div=0.

Reset
REQ-028 While reset is high: state=IDLE, level=0, pointers=0, counter=0, dac_code=mid-scale (1<<(DATA_W-1), 10'h200), dac_strobe=0, underflow=0, in_ready=1.
REQ-029 Reset asserted mid-RUN SHALL discard FIFO contents immediately, asynchronously.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding and the mid-scale constant.
REQ-031 The FIFO SHALL be a sub-module named dac_sample_fifo, providing push/pop, full, empty and level; the scheduler FSM and divider SHALL live in the top module.

Verification
REQ-032 Reset: reset pulse -> dac_code=0x200, in_ready=1, level=0, underflow=0.
REQ-033 Rate: rate_div=3; push 0x001,0x002,0x003; enable=1 -> codes appear in order 4 cycles apart, each with a one-cycle strobe.
REQ-034 Full: enable=0; push 9 samples -> the 9th is not accepted, level=8, in_ready=0.
REQ-035 Underflow: rate_div=1; push one sample; enable -> after the pop, the next tick sets underflow, dac_code holds, FSM re-enters PRIME; clr_underflow clears the flag.
REQ-036 Concurrency: rate_div=0 with a continuous push stream -> level stays constant; no loss or reordering across pointer wrap (>=20 samples).
REQ-037 Reset mid-RUN with level=5 -> level=0, dac_code=0x200, state IDLE, no strobe.

Source files
------------

// File: rtl/dac_sample_sched_pkg.sv
// Shared definitions for the DAC sample scheduler: FSM encoding and mid-scale code.
package dac_sample_sched_pkg;

  // Scheduler states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2
  } sched_state_e;

  // Mid-scale code for the default 10-bit DAC
  localparam logic [9:0] MidScale = 10'h200;

  // Mid-scale code (MSB set) for an arbitrary DAC width
  function automatic logic [31:0] mid_scale_code(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Sample FIFO for the DAC scheduler. A push to a full FIFO is dropped even when a pop
// happens in the same cycle; pointers wrap modulo DEPTH (power of two).
module dac_sample_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   count_q;
  logic              push_ok, pop_ok;

  assign full     = (count_q == LvlW'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Storage write; contents need no reset since count_q gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + LvlW'(1);
        2'b01:   count_q <= count_q - LvlW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_sched.sv
// DAC sample scheduler: buffers producer samples and presents them to the DAC at a
// programmable rate, flagging underflow when a sample tick finds the FIFO empty.
module dac_sample_sched
  import dac_sample_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic                     clr_underflow,
  output logic [DATA_W-1:0]        dac_code,
  output logic                     dac_strobe,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [DATA_W-1:0] MidCode = DATA_W'(mid_scale_code(DATA_W));

  sched_state_e      state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dac_code_q;
  logic              dac_strobe_q, underflow_q;
  logic              tick, fifo_pop, uf_set;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign in_ready   = ~fifo_full;
  assign dac_code   = dac_code_q;
  assign dac_strobe = dac_strobe_q;
  assign underflow  = underflow_q;

  // State and divider registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and divider update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StPrime;
      end
      StPrime: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (!fifo_empty) begin
          state_d = StRun;
          cnt_d   = '0;  // first pop lands in the first RUN cycle
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          cnt_d = rate_div;
          if (fifo_empty) state_d = StPrime;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tick decode: pop on a populated tick, flag underflow on an empty one
  always_comb begin
    tick     = (state_q == StRun) && enable && (cnt_q == '0);
    fifo_pop = tick & ~fifo_empty;
    uf_set   = tick & fifo_empty;
  end

  // DAC output register, strobe and sticky underflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_code_q   <= MidCode;
      dac_strobe_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dac_strobe_q <= fifo_pop;
      if (fifo_pop) dac_code_q <= fifo_data;
      if (uf_set) begin
        underflow_q <= 1'b1;
      end else if (clr_underflow) begin
        underflow_q <= 1'b0;
      end
    end
  end

endmodule
